// File: rtl/tmp_rob_ctrl.sv
// rtl/tmp_rob_ctrl.sv - in-order allocate/update/retire controller for the temp register file
module tmp_rob_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          disp_valid,
    output logic          disp_ready,
    input  logic [3:0]    disp_rd,
    input  logic [32:0]   disp_pc,
    input  logic [1:0]    disp_type,
    output logic [AW-1:0] disp_tag,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_tag,
    input  logic          wb_spec_data,
    output logic [41:0]   rf_data_in,
    output logic [AW-1:0] rf_waddr,
    output logic          rf_new_entry,
    output logic          rf_update_entry,
    output logic [AW-1:0] rf_rd_addr1,
    input  logic [41:0]   rf_data_out1,
    output logic          cmt_valid,
    input  logic          cmt_ready,
    output logic [3:0]    cmt_rd,
    output logic [32:0]   cmt_pc,
    output logic [1:0]    cmt_type,
    output logic          cmt_spec_data
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW-1:0] wb_off;
    logic          wb_in_window;
    logic          wb_accept;
    logic          disp_fire;
    logic          cmt_fire;

    // Window test: distance from head (mod DEPTH) must fall inside the occupied span.
    assign wb_off       = wb_tag - head;
    assign wb_in_window = wb_valid && ({1'b0, wb_off} < count);
    assign wb_accept    = !reset && !flush && wb_in_window;

    assign disp_ready = !reset && !flush && (count < FULL) && !wb_in_window;
    assign disp_tag   = tail;
    assign disp_fire  = disp_valid && disp_ready;

    assign rf_rd_addr1 = head;
    assign cmt_valid   = !reset && !flush && (count != '0) && rf_data_out1[0] && rf_data_out1[1];
    assign cmt_fire    = cmt_valid && cmt_ready;

    assign cmt_rd        = rf_data_out1[41:38];
    assign cmt_pc        = rf_data_out1[37:5];
    assign cmt_type      = rf_data_out1[4:3];
    assign cmt_spec_data = rf_data_out1[2];

    // Single shared write port: writeback wins over dispatch.
    always_comb begin
        rf_data_in      = '0;
        rf_waddr        = '0;
        rf_new_entry    = 1'b0;
        rf_update_entry = 1'b0;
        if (wb_accept) begin
            rf_update_entry = 1'b1;
            rf_waddr        = wb_tag;
            rf_data_in      = {39'b0, wb_spec_data, 1'b1, 1'b0};
        end else if (disp_fire) begin
            rf_new_entry = 1'b1;
            rf_waddr     = tail;
            rf_data_in   = {disp_rd, disp_pc, disp_type, 3'b001};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (disp_fire) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (cmt_fire) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            case ({disp_fire, cmt_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
